// File: rtl/pixels_ctrl_pkg.sv
// Shared line geometry, bus word types and controller state type for pixels_ctrl.
package pixels_ctrl_pkg;

  localparam int unsigned WORDS_PER_LINE  = 80;
  localparam int unsigned PIXELS_PER_WORD = 16;
  localparam int unsigned PIXELS_PER_LINE = WORDS_PER_LINE * PIXELS_PER_WORD;

  typedef logic [4*PIXELS_PER_WORD-1:0] word_t;
  typedef logic [6:0]                   waddr_t;
  typedef logic [10:0]                  paddr_t;

  localparam waddr_t LAST_WORD  = waddr_t'(WORDS_PER_LINE - 1);
  localparam paddr_t LAST_PIXEL = paddr_t'(PIXELS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL,
    SHOW
  } state_e;

endpackage

// File: rtl/pixels_ctrl_if.sv
// Source-word handshake plus line RAM write/read bus around pixels_ctrl.
interface pixels_ctrl_if;
  import pixels_ctrl_pkg::*;

  logic   src_valid;
  word_t  src_data;
  logic   src_ready;
  logic   wr_en;
  waddr_t wr_addr;
  word_t  wr_data;
  paddr_t rd_addr;
  logic   rd_valid;

  // master: the controller; slave: the word source and line RAM side
  modport master (
    input  src_valid, src_data,
    output src_ready, wr_en, wr_addr, wr_data, rd_addr, rd_valid
  );

  modport slave (
    output src_valid, src_data,
    input  src_ready, wr_en, wr_addr, wr_data, rd_addr, rd_valid
  );

endinterface

// File: rtl/pixels_ctrl.sv
// Line buffer controller: fills an 80-word line RAM, then reads out 1280 pixels.
// Optional underrun flag/counter ports exist only with PIXELS_CTRL_UNDERRUN_EN.
module pixels_ctrl
  import pixels_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   line_start,
  input  logic   disp_start,
  input  logic   pix_ce,
  input  logic   src_valid,
  input  word_t  src_data,
  output logic   src_ready,
  output logic   wr_en,
  output waddr_t wr_addr,
  output word_t  wr_data,
  output paddr_t rd_addr,
  output logic   rd_valid,
  output logic   busy,
  output logic   fill_done
`ifdef PIXELS_CTRL_UNDERRUN_EN
  ,
  output logic       underrun,
  output logic [7:0] underrun_cnt
`endif
);

  state_e state_q, state_d;
  waddr_t wcnt_q, wcnt_d;
  paddr_t rd_addr_q, rd_addr_d;
  logic   pend_q, pend_d;
  logic   wr_en_q, wr_en_d;
  waddr_t wr_addr_q, wr_addr_d;
  word_t  wr_data_q, wr_data_d;
  logic   rd_valid_q, rd_valid_d;
  logic   fill_done_q, fill_done_d;
  logic   accept;

  assign src_ready = (state_q == FILL) && (wcnt_q <= LAST_WORD);
  assign accept    = src_valid && src_ready;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rd_addr_d   = rd_addr_q;
    pend_d      = pend_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    fill_done_d = 1'b0;
    rd_valid_d  = pix_ce && (state_q == SHOW);

    unique case (state_q)
      IDLE: begin
        if (disp_start) begin
          state_d   = SHOW;
          rd_addr_d = '0;
          pend_d    = line_start;
        end else if (line_start) begin
          state_d = FILL;
          wcnt_d  = '0;
        end
      end
      FILL: begin
        // underrun wins over a same-cycle handshake: that word is dropped
        if (disp_start) begin
          state_d   = SHOW;
          rd_addr_d = '0;
        end else if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wcnt_q;
          wr_data_d = src_data;
          wcnt_d    = wcnt_q + 7'd1;
          if (wcnt_q == LAST_WORD) begin
            state_d     = FULL;
            fill_done_d = 1'b1;
          end
        end
      end
      FULL: begin
        if (disp_start) begin
          state_d   = SHOW;
          rd_addr_d = '0;
          pend_d    = line_start;
        end else if (line_start) begin
          state_d = FILL;
          wcnt_d  = '0;
        end
      end
      SHOW: begin
        if (line_start) pend_d = 1'b1;
        if (pix_ce) begin
          if (rd_addr_q == LAST_PIXEL) begin
            rd_addr_d = '0;
            if (pend_q || line_start) begin
              state_d = FILL;
              wcnt_d  = '0;
              pend_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            rd_addr_d = rd_addr_q + 11'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      rd_addr_q   <= '0;
      pend_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rd_addr_q   <= rd_addr_d;
      pend_q      <= pend_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_valid_q  <= rd_valid_d;
      fill_done_q <= fill_done_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = rd_addr_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = (state_q != IDLE);
  assign fill_done = fill_done_q;

`ifdef PIXELS_CTRL_UNDERRUN_EN
  logic       underrun_q;
  logic [7:0] underrun_cnt_q;
  logic       underrun_ev;

  assign underrun_ev = disp_start && ((state_q == IDLE) || (state_q == FILL));

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else if (underrun_ev) begin
      underrun_q <= 1'b1;
      if (underrun_cnt_q != 8'hFF) underrun_cnt_q <= underrun_cnt_q + 8'd1;
    end
  end

  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_pixels_ctrl.sv
// Randomized self-checking bench for pixels_ctrl against a transaction-level line model.
module tb_pixels_ctrl;
  import pixels_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic line_start = 1'b0;
  logic disp_start = 1'b0;
  logic pix_ce = 1'b0;
  logic busy, fill_done;
`ifdef PIXELS_CTRL_UNDERRUN_EN
  logic       underrun;
  logic [7:0] underrun_cnt;
`endif

  pixels_ctrl_if bus();

  pixels_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .disp_start (disp_start),
    .pix_ce     (pix_ce),
    .src_valid  (bus.src_valid),
    .src_data   (bus.src_data),
    .src_ready  (bus.src_ready),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .wr_data    (bus.wr_data),
    .rd_addr    (bus.rd_addr),
    .rd_valid   (bus.rd_valid),
    .busy       (busy),
    .fill_done  (fill_done)
`ifdef PIXELS_CTRL_UNDERRUN_EN
    ,
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // expected line contents: word i goes to address i
  logic [63:0] words [80];
  int          wa_q [$];
  logic [63:0] wd_q [$];
  int          fd_cnt, fd_addr, rv_cnt;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wa_q.push_back(int'(bus.wr_addr));
      wd_q.push_back(bus.wr_data);
    end
    if (fill_done === 1'b1) begin
      fd_cnt++;
      fd_addr = int'(bus.wr_addr);
    end
    if (bus.rd_valid === 1'b1) rv_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    fd_cnt  = 0;
    fd_addr = -1;
    rv_cnt  = 0;
  endtask

  task automatic new_words();
    foreach (words[i]) words[i] = {$urandom, $urandom};
  endtask

  task automatic start_fill();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("fill_entry_ready", bus.src_ready, 1);
    check("fill_entry_busy", busy, 1);
  endtask

  // offers words until n handshakes; stray line_start pulses must be ignored
  task automatic feed(input int n, input int pct);
    int   got = 0;
    int   guard = 0;
    int   lat_err = 0;
    logic hs;
    while (got < n && guard < 5000) begin
      bus.src_valid = ($urandom_range(99) < pct);
      bus.src_data  = bus.src_valid ? words[got] : {$urandom, $urandom};
      line_start    = (pct < 100) && ($urandom_range(15) == 0);
      hs = bus.src_valid && bus.src_ready;
      tick();
      guard++;
      if (bus.wr_en !== hs) lat_err++;
      if (hs) got++;
    end
    bus.src_valid = 1'b0;
    line_start    = 1'b0;
    check("feed_count", got, n);
    check("wr_latency", lat_err, 0);
  endtask

  task automatic check_writes(input int n);
    int err = 0;
    check("wr_count", wa_q.size(), n);
    for (int i = 0; i < wa_q.size() && i < n; i++)
      if (wa_q[i] != i || wd_q[i] !== words[i]) err++;
    check("wr_sequence", err, 0);
  endtask

  // mode 0: random pix_ce; mode k>0: pix_ce every k-th cycle
  task automatic show(input int mode, input bit inject, input bit exp_pend);
    int   n = 0;
    int   guard = 0;
    int   aerr = 0;
    int   verr = 0;
    logic ce;
    rv_cnt = 0;
    while (n < PIXELS_PER_LINE && guard < 20000) begin
      if (int'(bus.rd_addr) != n) aerr++;
      ce = (mode == 0) ? ($urandom_range(1) == 1) : ((guard % mode) == mode - 1);
      pix_ce     = ce;
      line_start = inject && (guard == 700);
      disp_start = ($urandom_range(31) == 0);
      tick();
      guard++;
      if (bus.rd_valid !== ce) verr++;
      if (ce) n++;
    end
    pix_ce     = 1'b0;
    line_start = 1'b0;
    disp_start = 1'b0;
    check("show_len", n, PIXELS_PER_LINE);
    check("rd_addr_seq", aerr, 0);
    check("rd_valid_seq", verr, 0);
    check("show_end_busy", busy, exp_pend);
    check("show_end_ready", bus.src_ready, exp_pend);
    check("rd_addr_wrap", bus.rd_addr, 0);
    tick();
    check("rd_valid_cnt", rv_cnt, PIXELS_PER_LINE);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_src_ready"}, bus.src_ready, 0);
    check({tag, "_wr_en"}, bus.wr_en, 0);
    check({tag, "_wr_addr"}, bus.wr_addr, 0);
    check({tag, "_wr_data"}, bus.wr_data, 0);
    check({tag, "_rd_addr"}, bus.rd_addr, 0);
    check({tag, "_rd_valid"}, bus.rd_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fill_done"}, fill_done, 0);
`ifdef PIXELS_CTRL_UNDERRUN_EN
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_underrun_cnt"}, underrun_cnt, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    clear_mon();

    // reset state
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // full fill with continuous valid
    clear_mon();
    new_words();
    start_fill();
    feed(80, 100);
    check("fill_done_last", fill_done, 1);
    check("full_ready", bus.src_ready, 0);
    check("full_busy", busy, 1);
    repeat (3) tick();
    check("fd_count", fd_cnt, 1);
    check("fd_addr", fd_addr, 79);
    check_writes(80);

    // backpressure: restart from FULL, 50% valid
    clear_mon();
    new_words();
    start_fill();
    feed(80, 50);
    tick();
    check("bp_fd_count", fd_cnt, 1);
    check_writes(80);

    // readout from FULL, pix_ce every 2nd cycle, back to IDLE
    disp_start = 1'b1;
    tick();
    disp_start = 1'b0;
    check("show_entry_rd_addr", bus.rd_addr, 0);
    check("show_entry_busy", busy, 1);
    show(2, 1'b0, 1'b0);

    // underrun after 40 words, with a word in flight on the disp_start cycle
    clear_mon();
    new_words();
    start_fill();
    feed(40, 100);
    bus.src_valid = 1'b1;
    bus.src_data  = words[40];
    disp_start    = 1'b1;
    tick();
    disp_start    = 1'b0;
    bus.src_valid = 1'b0;
    check("ur_discard", bus.wr_en, 0);
    check("ur_ready", bus.src_ready, 0);
    check("ur_busy", busy, 1);
`ifdef PIXELS_CTRL_UNDERRUN_EN
    check("ur_flag", underrun, 1);
    check("ur_cnt", underrun_cnt, 1);
`endif
    show(0, 1'b0, 1'b0);
    check_writes(40);
    check("ur_fd_count", fd_cnt, 0);

    // pending line_start during SHOW
    clear_mon();
    new_words();
    start_fill();
    feed(80, 100);
    tick();
    disp_start = 1'b1;
    tick();
    disp_start = 1'b0;
    show(0, 1'b1, 1'b1);

    // the pending fill starts right after readout
    clear_mon();
    new_words();
    feed(80, 60);
    tick();
    check_writes(80);

    // coincident line_start + disp_start in FULL
    line_start = 1'b1;
    disp_start = 1'b1;
    tick();
    line_start = 1'b0;
    disp_start = 1'b0;
    check("coinc_busy", busy, 1);
    check("coinc_ready", bus.src_ready, 0);
    check("coinc_rd_addr", bus.rd_addr, 0);
`ifdef PIXELS_CTRL_UNDERRUN_EN
    check("coinc_no_underrun", underrun_cnt, 1);
`endif
    show(2, 1'b0, 1'b1);

    // reset at word 30 of the pending fill
    clear_mon();
    new_words();
    feed(30, 100);
    reset         = 1'b1;
    bus.src_valid = 1'b1;
    bus.src_data  = words[30];
    tick();
    check_all_zero("mid_reset");
    reset         = 1'b0;
    bus.src_valid = 1'b0;
    tick();
    check("post_reset_wr_en", bus.wr_en, 0);
    check_writes(30);

    // new fill restarts at address 0
    clear_mon();
    new_words();
    start_fill();
    feed(80, 50);
    tick();
    check_writes(80);
    check("restart_fd_addr", fd_addr, 79);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixels_ctrl.md
PIXELS_CTRL -- requirements
Module: pixels_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port line_start, input, 1 bit: single-cycle pulse requesting a fill of the next line.
REQ-004 SHALL have port disp_start, input, 1 bit: single-cycle pulse starting readout of the active line.
REQ-005 SHALL have port pix_ce, input, 1 bit: pixel-rate enable; readout advances only when high.
REQ-006 SHALL have port src_valid, input, 1 bit: source word valid.
REQ-007 SHALL have port src_data, input, 64 bits: 16 pixels of 4 bits each, pixel 0 in bits [3:0].
REQ-008 SHALL have port src_ready, output, 1 bit: controller accepts a source word.
REQ-009 SHALL have port wr_en, output, 1 bit: write strobe to the line RAM.
REQ-010 SHALL have port wr_addr, output, 7 bits: line RAM word address.
REQ-011 SHALL have port wr_data, output, 64 bits: line RAM write word.
REQ-012 SHALL have port rd_addr, output, 11 bits: line RAM pixel address.
REQ-013 SHALL have port rd_valid, output, 1 bit: the RAM pixel output is valid this cycle.
REQ-014 SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-015 SHALL have port fill_done, output, 1 bit: one-cycle pulse when the 80th word has been written.
REQ-016 SHALL have port underrun, output, 1 bit: sticky flag; exists only under the configuration macro.
REQ-017 SHALL have port underrun_cnt, output, 8 bits: saturating count; exists only under the configuration macro.

Function
REQ-018 SHALL use the states IDLE, FILL, FULL and SHOW.
REQ-019 SHALL go from IDLE or FULL to FILL on line_start, clearing the word counter.
REQ-020 SHALL drive src_ready high only in FILL while the word count is below 80.
REQ-021 SHALL, on a src_valid and src_ready handshake, register wr_en=1, wr_addr=word count and wr_data=src_data in the next cycle, then increment the count.
REQ-022 SHALL, after accepting word 79, enter FULL with src_ready low, and pulse fill_done in the cycle wr_en writes address 79.
REQ-023 SHALL go from FULL to SHOW on disp_start, with rd_addr=0.
REQ-024 SHALL, in SHOW, advance rd_addr by 1 per cycle with pix_ce high, and hold it otherwise.
REQ-025 SHALL drive rd_valid as pix_ce gated by SHOW, delayed one cycle to match the RAM read latency.
REQ-026 SHALL, on the pix_ce cycle at rd_addr=1279, return to IDLE, with rd_addr wrapping to 0.
REQ-027 SHALL treat disp_start in FILL or IDLE as an underrun: abort any fill, discard a word in flight, enter SHOW.
REQ-028 SHALL latch line_start received in SHOW as pending, and enter FILL in the cycle after SHOW ends.
REQ-029 SHALL give disp_start priority when line_start and disp_start coincide in FULL; line_start becomes pending.
REQ-030 SHALL ignore line_start received in FILL.
REQ-031 SHALL ignore disp_start received in SHOW.

Reset
REQ-032 SHALL, on reset, set state=IDLE and clear the counters and pending flag.
REQ-033 SHALL, on reset, drive all outputs to 0, including src_ready, wr_en and underrun_cnt.
REQ-034 SHALL let reset mid-FILL or mid-SHOW abort immediately, with no write issued in the following cycle.

Configuration
REQ-035 SHALL, with PIXELS_CTRL_UNDERRUN_EN defined, set underrun and increment underrun_cnt (saturating at 255) on each underrun event.
REQ-036 SHALL, with PIXELS_CTRL_UNDERRUN_EN defined, clear underrun and underrun_cnt only by reset.
REQ-037 SHALL, without PIXELS_CTRL_UNDERRUN_EN, omit underrun and underrun_cnt and their logic; REQ-027 behaviour is unchanged.

Structure
REQ-038 SHALL place in the shared package pixels_ctrl_pkg: WORDS_PER_LINE=80, PIXELS_PER_WORD=16, PIXELS_PER_LINE=1280 and the state enum type.
REQ-039 SHALL be implemented as a single module with no sub-module; its outputs connect directly to the line RAM write port (addra/dia/cea) and read port (addrb).

Verification
REQ-040 SHALL cover a full fill: line_start, then 80 words with src_valid always high -> wr_addr 0..79 consecutive, fill_done one cycle at word 79, state FULL.
REQ-041 SHALL cover backpressure: src_valid toggling 50% -> exactly 80 writes, no duplicated or skipped addresses.
REQ-042 SHALL cover readout: disp_start from FULL with pix_ce every 2nd cycle -> rd_addr 0..1279, rd_valid 1280 pulses, return to IDLE.
REQ-043 SHALL cover underrun: disp_start after 40 words -> SHOW entered, no further writes, underrun=1, underrun_cnt=1 (with the macro).
REQ-044 SHALL cover the pending request: line_start during SHOW and a coincident line_start+disp_start in FULL -> FILL starts the cycle after rd_addr 1279.
REQ-045 SHALL cover reset at word 30 of a fill -> all outputs 0 next cycle, and a new fill restarts at wr_addr 0.
